// File: rtl/multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package multiplier_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Wide enough to hold the step count BITS without wrapping.
  function automatic int cnt_width(input int bits);
    return $clog2(bits) + 1;
  endfunction

endpackage

// File: rtl/multiplier_mul_step.sv
// One shift-and-add step: sum = acc + (sel ? addend : 0).
module mul_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  input  logic         sel,
  output logic [W-1:0] sum
);

  assign sum = acc + (sel ? addend : '0);

endmodule

// File: rtl/multiplier.sv
// Unsigned sequential multiplier retiring one multiplier bit per clock;
// the product is registered and held with o_finished until the next start.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [BITS-1:0]   i_multiplicand,
  input  logic [BITS-1:0]   i_multiplier,
  output logic [2*BITS-1:0] o_product,
  output logic              o_finished,
  output logic              o_busy
);

  localparam int W  = 2 * BITS;
  localparam int CW = cnt_width(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic [W-1:0]    acc;
  logic [W-1:0]    a_sh;   // multiplicand pre-shifted to the weight of the next bit
  logic [BITS-1:0] b_sh;   // remaining multiplier bits, current bit at [0]

  logic            accept;
  logic            last;
  logic [W-1:0]    step_acc;
  logic [W-1:0]    step_addend;
  logic            step_sel;
  logic [W-1:0]    sum;
  logic [W-1:0]    a_ext;

  assign a_ext  = {{BITS{1'b0}}, i_multiplicand};
  assign accept = (state == IDLE) && i_start;
  assign last   = accept ? (BITS == 1) : (count == LAST);
  assign o_busy = (state == RUN);

  // Bit 0 is folded into the accepting edge, so the step unit sees the raw
  // operands then; afterwards it works from the running registers.
  always_comb begin
    step_acc    = acc;
    step_addend = a_sh;
    step_sel    = b_sh[0];
    if (accept) begin
      step_acc    = '0;
      step_addend = a_ext;
      step_sel    = i_multiplier[0];
    end
  end

  mul_step #(.W(W)) u_step (
    .acc    (step_acc),
    .addend (step_addend),
    .sel    (step_sel),
    .sum    (sum)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = (BITS == 1) ? IDLE : RUN;
      RUN:     if (last)    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count      <= '0;
      acc        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      o_product  <= '0;
      o_finished <= 1'b0;
    end else if (accept || state == RUN) begin
      acc   <= sum;
      count <= accept ? CW'(1) : count + 1'b1;
      a_sh  <= accept ? (a_ext << 1) : (a_sh << 1);
      b_sh  <= accept ? (i_multiplier >> 1) : (b_sh >> 1);
      if (accept) o_finished <= 1'b0;
      if (last) begin
        o_product  <= sum;
        o_finished <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the sequential multiplier at BITS=4 and BITS=1.
module tb_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic [7:0] product;
  logic       finished, busy;

  logic       start1;
  logic [0:0] a1, b1;
  logic [1:0] product1;
  logic       finished1, busy1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multiplier #(.BITS(4)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_multiplicand (a),
    .i_multiplier   (b),
    .o_product      (product),
    .o_finished     (finished),
    .o_busy         (busy)
  );

  multiplier #(.BITS(1)) dut1 (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start1),
    .i_multiplicand (a1),
    .i_multiplier   (b1),
    .o_product      (product1),
    .o_finished     (finished1),
    .o_busy         (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a BITS=4 operation and check latency plus result.
  task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] exp);
    a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " fin e1"}, finished, 0);
    step();
    step();
    chk({tag, " fin e3"}, finished, 0);
    chk({tag, " busy e3"}, busy, 1);
    step();
    chk({tag, " fin e4"}, finished, 1);
    chk({tag, " prod"}, product, exp);
    chk({tag, " busy e4"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #2;
    chk("rst prod", product, 0);
    chk("rst fin", finished, 0);
    chk("rst busy", busy, 0);
    chk("rst1 fin", finished1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    run_op("13x11", 4'd13, 4'd11, 8'd143);

    // Idle hold: product and flag persist with no start.
    step(); step(); step();
    chk("hold fin", finished, 1);
    chk("hold prod", product, 143);

    // Start held for 4 edges: accepted once, extra requests ignored.
    a = 4'd15; b = 4'd15; start = 1'b1;
    step();
    chk("hold-start fin e1", finished, 0);
    chk("hold-start busy e1", busy, 1);
    a = 4'd2; b = 4'd3;   // must not disturb the running operation
    step(); step(); step();
    chk("hold-start fin e4", finished, 1);
    chk("hold-start prod", product, 225);
    start = 1'b0;

    run_op("0x9", 4'd0, 4'd9, 8'd0);
    run_op("7x1", 4'd7, 4'd1, 8'd7);

    // Reset between edges 2 and 3 of an operation.
    a = 4'd9; b = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst prod", product, 0);
    chk("midrst fin", finished, 0);
    chk("midrst busy", busy, 0);
    #1;
    rst = 1'b0;
    run_op("5x6", 4'd5, 4'd6, 8'd30);

    // Exhaustive back-to-back sweep, one start every 4 cycles.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i); b = 4'(j); start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk($sformatf("sweep %0dx%0d", i, j), {finished, product}, {1'b1, 8'(i * j)});
      end
    end

    // BITS=1: finishes on the start edge itself.
    a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("b1 1x1 fin", finished1, 1);
    chk("b1 1x1 prod", product1, 1);
    chk("b1 1x1 busy", busy1, 0);
    a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("b1 1x0 prod", product1, 0);
    chk("b1 1x0 fin", finished1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Unsigned sequential shift-and-add multiplier. It takes two BITS-wide operands on a one-cycle start strobe and retires one multiplier bit per clock. It then presents a 2·BITS-wide product with a level `o_finished` flag. It is a standalone arithmetic unit driven by a controller that polls `o_finished`; the free-running clock source is external and not part of this block.

## Interface
- `BITS`, default 4: operand width; legal range is BITS ≥ 1.
- `i_clock`  in  1: the single clock; all state updates on its rising edge.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_start`  in  1: start request; sampled on the rising edge.
- `i_multiplicand`  in  BITS: operand A, unsigned; sampled when a start is accepted.
- `i_multiplier`  in  BITS: operand B, unsigned; sampled when a start is accepted.
- `o_product`  out  2·BITS: A·B; valid while `o_finished`=1.
- `o_finished`  out  1: high when the product is valid; held until the next accepted start or reset.
- `o_busy`  out  1: high while an operation is in progress.

## Operation
- The block has two states: IDLE and RUN.
  - `o_busy` = (state == RUN).
  - `o_finished` is a separate register.
- Reset, applied asynchronously:
  - state goes to IDLE;
  - the step counter, accumulator, `o_product` and `o_finished` go to 0;
  - `o_busy` goes to 0.
- A start is accepted on a rising edge where `i_start`=1 and state is IDLE. IDLE covers both before the first operation and after a finish. On acceptance:
  - A is latched, and B is latched into a shift register;
  - `o_finished` is cleared;
  - bit 0 is processed in the same edge: accumulator = B[0] ? A : 0;
  - the step counter is set to 1.
  - If BITS=1, the operation finishes on this same edge.
- RUN, each rising edge processes bit i of B: accumulator += B[i] ? (A << i) : 0, then the counter increments.
  - After step i the accumulator equals A·B[i:0].
  - Shift-right-accumulator and shifted-addend realisations are both acceptable.
- Finish happens on the edge that processes bit BITS−1:
  - `o_product` is loaded with the final sum;
  - `o_finished` goes to 1;
  - state returns to IDLE.
- `i_start` while in RUN is ignored. This includes the finishing edge. The operation is neither restarted nor corrupted.
- If `i_start` is still high on the first edge after a finish, the block is IDLE and a new operation starts; `o_finished` drops.
- Arithmetic is unsigned with no overflow possible: max product is (2^BITS−1)² < 2^(2·BITS).
- `o_product` is registered and changes only on the finishing edge and on reset. Intermediate sums are not visible.

## Timing
- If a start is accepted on edge k, `o_finished` and `o_product` are valid after edge k+BITS−1.
  - That is, BITS edges including the start edge.
  - For BITS=4 with start sampled at edge 1, `o_finished`=1 after edge 4.
- Throughput: a new start may be accepted on edge k+BITS. This gives back-to-back operations every BITS cycles.
- `o_finished` stays high indefinitely while idle with no start.
- Reset asserted mid-operation:
  - the operation is aborted immediately, without waiting for a clock edge;
  - outputs go to 0;
  - a start on the first edge after reset deasserts is accepted.
- Reset has priority over start on the same edge.

## Structure
- The shared package holds:
  - the state enum (IDLE, RUN);
  - a function returning the counter width, $clog2(BITS)+1.
- One sub-module is natural: `mul_step`, a combinational adder computing accumulator + (bit ? shifted A : 0).
- The control FSM, counter and registers stay in the top module.

## Test plan
- Reset, then start with A=13, B=11, BITS=4, start high for one cycle:
  - `o_finished`=0 after edges 1–3;
  - `o_finished`=1 and `o_product`=143 after edge 4.
- Hold `i_start` high for 4 cycles starting after a finish, with A=15, B=15:
  - the start is accepted once and the extra starts are ignored;
  - `o_product`=225 and `o_finished`=1 after the 4th edge.
- Multiply by zero and by one:
  - A=0, B=9 gives 0;
  - A=7, B=1 gives 7.
  - Both have the same 4-cycle latency.
- Assert `i_reset` between edges 2 and 3 of an operation:
  - `o_product`=0, `o_finished`=0 and `o_busy`=0 immediately;
  - a new start (A=5, B=6) then yields 30.
- Exhaustive sweep at BITS=4, all 256 operand pairs, back-to-back with a start every 4 cycles:
  - every product matches A·B.
- BITS=1:
  - A=1, B=1 gives `o_product`=1 and `o_finished`=1 after the start edge itself.
